// File: rtl/svi_lane_collector.sv
// svi_lane_collector: captures per-lane {a,b,c} words from an array of SVI lanes,
// arbitrates round-robin across lanes and serialises the words onto one
// valid/ready output tagged with the lane index; counts overrun drops.
module svi_lane_collector #(
    parameter int N_LANES = 4,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_LANES-1:0] i_vld,
    input  logic [N_LANES-1:0] i_a,
    input  logic [N_LANES-1:0] i_b,
    input  logic [N_LANES-1:0] i_c,
    output logic               o_vld,
    input  logic               i_rdy,
    output logic [2:0]         o_data,
    output logic [IDX_W-1:0]   o_lane,
    output logic [N_LANES-1:0] o_pend,
    output logic [CNT_W-1:0]   o_drop_cnt
);

    // Wide enough to add up to 16 drops onto a full counter without overflow
    localparam int SUM_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W:0] LANES_L = (IDX_W + 1)'(N_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

    logic [N_LANES-1:0] r_pend;
    logic [2:0]         r_word [N_LANES];
    logic [IDX_W-1:0]   r_ptr;
    logic               r_vld;
    logic [2:0]         r_data;
    logic [IDX_W-1:0]   r_lane;
    logic [CNT_W-1:0]   r_drop;

    logic               w_free;
    logic               w_gntFound;
    logic [IDX_W-1:0]   w_gntIdx;
    logic               w_grant;
    logic [N_LANES-1:0] w_gntHot;
    logic [N_LANES-1:0] w_drop;
    logic [SUM_W-1:0]   w_dropNum;
    logic [SUM_W-1:0]   w_dropSum;
    logic [CNT_W-1:0]   w_dropNext;
    logic [IDX_W-1:0]   w_ptrNext;

    // Output register can take a new word when empty or being drained this cycle
    assign w_free  = !r_vld || i_rdy;
    assign w_grant = w_free && w_gntFound;

    // Find the first pending lane at or above the pointer, wrapping around
    always_comb begin
        logic [IDX_W:0] idx;
        w_gntFound = 1'b0;
        w_gntIdx   = '0;
        idx        = '0;
        for (int i = 0; i < N_LANES; i++) begin
            idx = {1'b0, r_ptr} + (IDX_W + 1)'(i);
            if (idx >= LANES_L) idx = idx - LANES_L;
            if (!w_gntFound && r_pend[idx[IDX_W-1:0]]) begin
                w_gntFound = 1'b1;
                w_gntIdx   = idx[IDX_W-1:0];
            end
        end
    end

    // One-hot grant and per-lane overrun detection; a granted lane accepts a new word
    always_comb begin
        w_gntHot  = '0;
        w_drop    = '0;
        w_dropNum = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_gntHot[k] = w_grant && (w_gntIdx == IDX_W'(k));
            w_drop[k]   = i_vld[k] && r_pend[k] && !w_gntHot[k];
            w_dropNum   = w_dropNum + SUM_W'(w_drop[k]);
        end
    end

    // Saturating drop counter update and wrapped pointer advance
    always_comb begin
        w_dropSum  = SUM_W'(r_drop) + w_dropNum;
        w_dropNext = (w_dropSum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_dropSum[CNT_W-1:0];
        w_ptrNext  = (w_gntIdx == LAST_IDX) ? '0 : w_gntIdx + IDX_W'(1);
    end

    // Per-lane single-word storage: capture wins over the grant clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
            for (int k = 0; k < N_LANES; k++) r_word[k] <= '0;
        end else begin
            for (int k = 0; k < N_LANES; k++) begin
                if (i_vld[k] && (!r_pend[k] || w_gntHot[k])) begin
                    r_word[k] <= {i_a[k], i_b[k], i_c[k]};
                    r_pend[k] <= 1'b1;
                end else if (w_gntHot[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end
        end
    end

    // Registered output stage, round-robin pointer and drop counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_lane <= '0;
            r_ptr  <= '0;
            r_drop <= '0;
        end else begin
            r_drop <= w_dropNext;
            if (w_grant) begin
                r_vld  <= 1'b1;
                r_data <= r_word[w_gntIdx];
                r_lane <= w_gntIdx;
                r_ptr  <= w_ptrNext;
            end else if (w_free) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign o_vld      = r_vld;
    assign o_data     = r_data;
    assign o_lane     = r_lane;
    assign o_pend     = r_pend;
    assign o_drop_cnt = r_drop;

endmodule

// File: tb/tb_svi_lane_collector.sv
// Directed self-checking bench for svi_lane_collector: a 4-lane instance for
// capture, arbitration, backpressure, collision and async reset, and a 1-lane
// instance with a 2-bit drop counter for saturation.
module tb_svi_lane_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic [3:0] vld, a, b, c;
    logic       oVld;
    logic [2:0] oData;
    logic [1:0] oLane;
    logic [3:0] oPend;
    logic [7:0] oDrop;

    logic [0:0] sVld, sA, sB, sC;
    logic       sRdy;
    logic       sOvld;
    logic [2:0] sData;
    logic [0:0] sLane;
    logic [0:0] sPend;
    logic [1:0] sDrop;

    int checkCount = 0;
    int failCount  = 0;

    svi_lane_collector #(.N_LANES(4), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_a(a), .i_b(b), .i_c(c),
        .o_vld(oVld), .i_rdy(rdy), .o_data(oData), .o_lane(oLane),
        .o_pend(oPend), .o_drop_cnt(oDrop)
    );

    svi_lane_collector #(.N_LANES(1), .CNT_W(2)) dutSat (
        .i_clk(clk), .i_rst(rst), .i_vld(sVld), .i_a(sA), .i_b(sB), .i_c(sC),
        .o_vld(sOvld), .i_rdy(sRdy), .o_data(sData), .o_lane(sLane),
        .o_pend(sPend), .o_drop_cnt(sDrop)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the 4-lane strobes; words packs lane k's {a,b,c} in bits [3k+2:3k]
    task automatic applyStimulus(input logic [3:0] v, input logic [11:0] words);
        vld = v;
        for (int k = 0; k < 4; k++) begin
            a[k] = words[3*k+2];
            b[k] = words[3*k+1];
            c[k] = words[3*k];
        end
    endtask

    task automatic applySat(input logic v, input logic [2:0] w);
        sVld[0] = v;
        sA[0]   = w[2];
        sB[0]   = w[1];
        sC[0]   = w[0];
    endtask

    // Directed scenario sequence
    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        sRdy = 1'b1;
        applyStimulus(4'b0000, 12'h000);
        applySat(1'b0, 3'b000);

        // Reset then idle
        repeat (3) begin
            step();
            checkOutput("rst_vld", oVld, 0);
            checkOutput("rst_pend", oPend, 0);
            checkOutput("rst_drop", oDrop, 0);
        end
        rst = 1'b0;
        repeat (10) begin
            step();
            checkOutput("idle_vld", oVld, 0);
            checkOutput("idle_pend", oPend, 0);
            checkOutput("idle_drop", oDrop, 0);
        end

        // Single lane, 2-bit counter: collision, saturation and held output
        sRdy = 1'b0;
        applySat(1'b1, 3'b101);
        step();
        checkOutput("sat_pend1", sPend, 1);
        checkOutput("sat_vld0", sOvld, 0);
        applySat(1'b1, 3'b010);
        step();
        checkOutput("sat_vld1", sOvld, 1);
        checkOutput("sat_data1", sData, 3'b101);
        checkOutput("sat_pend2", sPend, 1);
        checkOutput("sat_drop0", sDrop, 0);
        applySat(1'b1, 3'b111);
        repeat (3) step();
        checkOutput("sat_drop3", sDrop, 3);
        repeat (2) step();
        checkOutput("sat_drop_hold", sDrop, 3);
        checkOutput("sat_data_hold", sData, 3'b101);
        checkOutput("sat_lane", sLane, 0);
        applySat(1'b0, 3'b000);
        sRdy = 1'b1;
        step();
        checkOutput("sat_vld2", sOvld, 1);
        checkOutput("sat_data2", sData, 3'b010);
        step();
        checkOutput("sat_vld_end", sOvld, 0);
        checkOutput("sat_drop_end", sDrop, 3);

        // Single capture on lane 2
        applyStimulus(4'b0100, {3'd0, 3'b101, 3'd0, 3'd0});
        step();
        applyStimulus(4'b0000, 12'h000);
        checkOutput("cap_pend", oPend, 4'b0100);
        checkOutput("cap_vld0", oVld, 0);
        step();
        checkOutput("cap_vld1", oVld, 1);
        checkOutput("cap_data", oData, 3'b101);
        checkOutput("cap_lane", oLane, 2);
        checkOutput("cap_pend_clr", oPend, 0);
        step();
        checkOutput("cap_vld_end", oVld, 0);

        // Lane 3 word moves the pointer back to 0
        applyStimulus(4'b1000, {3'b110, 3'd0, 3'd0, 3'd0});
        step();
        applyStimulus(4'b0000, 12'h000);
        step();
        checkOutput("l3_lane", oLane, 3);
        checkOutput("l3_data", oData, 3'b110);
        step();

        // Round-robin from pointer 0
        applyStimulus(4'b1111, {3'd3, 3'd2, 3'd1, 3'd0});
        step();
        applyStimulus(4'b0000, 12'h000);
        checkOutput("rr0_pend", oPend, 4'b1111);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("rr0_vld", oVld, 1);
            checkOutput("rr0_lane", oLane, i);
            checkOutput("rr0_data", oData, i);
        end
        step();
        checkOutput("rr0_vld_end", oVld, 0);
        checkOutput("rr0_pend_end", oPend, 0);

        // Lane 1 word moves the pointer to 2
        applyStimulus(4'b0010, {3'd0, 3'd0, 3'b001, 3'd0});
        step();
        applyStimulus(4'b0000, 12'h000);
        step();
        checkOutput("l1_lane", oLane, 1);
        step();

        // Round-robin from pointer 2: order 2,3,0,1
        applyStimulus(4'b1111, {3'd7, 3'd6, 3'd5, 3'd4});
        step();
        applyStimulus(4'b0000, 12'h000);
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("rr2_lane", oLane, (2 + i) % 4);
            checkOutput("rr2_data", oData, 4 + ((2 + i) % 4));
        end
        step();
        checkOutput("rr2_vld_end", oVld, 0);

        // Backpressure: lane 0 stalls in the output, lane 1 pends then overruns
        rdy = 1'b0;
        applyStimulus(4'b0001, {3'd0, 3'd0, 3'd0, 3'b001});
        step();
        applyStimulus(4'b0000, 12'h000);
        step();
        checkOutput("bp_vld", oVld, 1);
        checkOutput("bp_lane0", oLane, 0);
        applyStimulus(4'b0010, {3'd0, 3'd0, 3'b011, 3'd0});
        step();
        applyStimulus(4'b0000, 12'h000);
        checkOutput("bp_pend", oPend, 4'b0010);
        repeat (2) begin
            step();
            checkOutput("bp_hold_vld", oVld, 1);
            checkOutput("bp_hold_data", oData, 3'b001);
            checkOutput("bp_hold_lane", oLane, 0);
        end
        applyStimulus(4'b0010, {3'd0, 3'd0, 3'b100, 3'd0});
        step();
        applyStimulus(4'b0000, 12'h000);
        checkOutput("bp_drop", oDrop, 1);
        checkOutput("bp_pend_keep", oPend, 4'b0010);
        checkOutput("bp_stall_data", oData, 3'b001);
        rdy = 1'b1;
        step();
        checkOutput("bp_rel_vld", oVld, 1);
        checkOutput("bp_rel_lane", oLane, 1);
        checkOutput("bp_rel_data", oData, 3'b011);
        checkOutput("bp_rel_pend", oPend, 0);
        step();
        checkOutput("bp_vld_end", oVld, 0);

        // Grant/capture collision on lane 3
        applyStimulus(4'b1000, {3'b010, 3'd0, 3'd0, 3'd0});
        step();
        checkOutput("col_pend", oPend, 4'b1000);
        applyStimulus(4'b1000, {3'b111, 3'd0, 3'd0, 3'd0});
        step();
        applyStimulus(4'b0000, 12'h000);
        checkOutput("col_lane", oLane, 3);
        checkOutput("col_data_old", oData, 3'b010);
        checkOutput("col_pend_keep", oPend, 4'b1000);
        checkOutput("col_nodrop", oDrop, 1);
        step();
        checkOutput("col_data_new", oData, 3'b111);
        checkOutput("col_lane2", oLane, 3);
        checkOutput("col_pend_clr", oPend, 0);
        step();
        checkOutput("col_vld_end", oVld, 0);
        checkOutput("col_drop_end", oDrop, 1);

        // Asynchronous reset between clock edges during a stalled transfer
        rdy = 1'b0;
        applyStimulus(4'b0100, {3'd0, 3'b101, 3'd0, 3'd0});
        step();
        applyStimulus(4'b0001, {3'd0, 3'd0, 3'd0, 3'b001});
        step();
        applyStimulus(4'b0000, 12'h000);
        checkOutput("ar_pre_vld", oVld, 1);
        checkOutput("ar_pre_lane", oLane, 2);
        checkOutput("ar_pre_pend", oPend, 4'b0001);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("ar_vld", oVld, 0);
        checkOutput("ar_data", oData, 0);
        checkOutput("ar_lane", oLane, 0);
        checkOutput("ar_pend", oPend, 0);
        checkOutput("ar_drop", oDrop, 0);
        step();
        step();
        checkOutput("ar_hold_vld", oVld, 0);
        rst = 1'b0;
        rdy = 1'b1;
        repeat (3) begin
            step();
            checkOutput("ar_idle_vld", oVld, 0);
            checkOutput("ar_idle_pend", oPend, 0);
        end
        applyStimulus(4'b0010, {3'd0, 3'd0, 3'b011, 3'd0});
        step();
        applyStimulus(4'b0000, 12'h000);
        checkOutput("ar_new_vld0", oVld, 0);
        checkOutput("ar_new_pend", oPend, 4'b0010);
        step();
        checkOutput("ar_new_vld", oVld, 1);
        checkOutput("ar_new_lane", oLane, 1);
        checkOutput("ar_new_data", oData, 3'b011);
        step();
        checkOutput("ar_new_end", oVld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
